processor_datapath: RTL and testbench

- Register-transfer datapath driven cycle-by-cycle by the processor sequencer's control strobes.
- Holds ACC, PC, IR, MAR and MDR on one shared internal bus, plus the ALU.
- Returns op and z_flag to the sequencer.
- Drives a single-port synchronous RAM through a MAR/MDR interface.

---
 rtl/processor_datapath.sv | 109 ++++++++++
 tb/tb_processor_datapath.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/processor_datapath.sv
// Accumulator-machine datapath: ACC/PC/IR/MAR/MDR on one shared bus plus ALU,
// sequenced externally by per-cycle control strobes, with a MAR/MDR RAM port.
module processor_datapath #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
) (
    input  logic                     clock,
    input  logic                     n_reset,
    input  logic                     ACC_bus,
    input  logic                     PC_bus,
    input  logic                     MDR_bus,
    input  logic                     Addr_bus,
    input  logic                     load_ACC,
    input  logic                     load_PC,
    input  logic                     load_IR,
    input  logic                     load_MAR,
    input  logic                     load_MDR,
    input  logic                     ALU_ACC,
    input  logic                     ALU_add,
    input  logic                     ALU_sub,
    input  logic                     ALU_xor,
    input  logic                     INC_PC,
    input  logic                     CS,
    input  logic                     R_NW,
    output logic [OP_W-1:0]          op,
    output logic                     z_flag,
    output logic [WORD_W-OP_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]        mem_wdata,
    input  logic [WORD_W-1:0]        mem_rdata,
    output logic                     mem_cs,
    output logic                     mem_we,
    output logic                     bus_conflict,
    output logic [WORD_W-1:0]        acc_q
);

    localparam int ADDR_W = WORD_W - OP_W;

    logic [WORD_W-1:0] r_acc;
    logic [ADDR_W-1:0] r_pc;
    logic [WORD_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_mar;
    logic [WORD_W-1:0] r_mdr;

    logic [WORD_W-1:0] w_bus;
    logic [WORD_W-1:0] w_alu;
    logic [2:0]        w_en_count;

    // Priority ACC > PC > MDR > Addr; conflicts are flagged, not prevented.
    always_comb begin
        w_bus = '0;
        if (ACC_bus)
            w_bus = r_acc;
        else if (PC_bus)
            w_bus = {{OP_W{1'b0}}, r_pc};
        else if (MDR_bus)
            w_bus = r_mdr;
        else if (Addr_bus)
            w_bus = {{OP_W{1'b0}}, r_ir[ADDR_W-1:0]};
    end

    always_comb begin
        w_en_count = {2'b00, ACC_bus} + {2'b00, PC_bus}
                   + {2'b00, MDR_bus} + {2'b00, Addr_bus};
    end

    always_comb begin
        w_alu = w_bus;
        if (ALU_add)
            w_alu = r_acc + w_bus;
        else if (ALU_sub)
            w_alu = r_acc - w_bus;
        else if (ALU_xor)
            w_alu = r_acc ^ w_bus;
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_acc <= '0;
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
        end else begin
            if (load_ACC)
                r_acc <= ALU_ACC ? w_alu : w_bus;
            if (load_PC)
                r_pc <= INC_PC ? r_pc + 1'b1 : w_bus[ADDR_W-1:0];
            if (load_IR)
                r_ir <= w_bus;
            if (load_MAR)
                r_mar <= w_bus[ADDR_W-1:0];
            // A bus load into MDR overrides a concurrent memory read.
            if (load_MDR)
                r_mdr <= w_bus;
            else if (CS && R_NW)
                r_mdr <= mem_rdata;
        end
    end

    assign op           = r_ir[WORD_W-1:ADDR_W];
    assign z_flag       = (r_acc == '0);
    assign mem_addr     = r_mar;
    assign mem_wdata    = r_mdr;
    assign mem_cs       = CS;
    assign mem_we       = CS & ~R_NW;
    assign bus_conflict = (w_en_count > 3'd1);
    assign acc_q        = r_acc;

endmodule

// File: tb/tb_processor_datapath.sv
// Directed + random bench for processor_datapath against a transfer-level
// model of the five registers.
module tb_processor_datapath;

    localparam logic [15:0] ACCB = 16'h8000, PCB  = 16'h4000, MDRB = 16'h2000,
                            ADRB = 16'h1000, LACC = 16'h0800, LPC  = 16'h0400,
                            LIR  = 16'h0200, LMAR = 16'h0100, LMDR = 16'h0080,
                            AACC = 16'h0040, ADD  = 16'h0020, SUB  = 16'h0010,
                            XOR  = 16'h0008, INC  = 16'h0004, CS   = 16'h0002,
                            RNW  = 16'h0001;

    logic        clock = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] ctl = '0;
    logic [7:0]  rdata = '0;

    logic [2:0]  op;
    logic        z_flag;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_cs, mem_we, bus_conflict;
    logic [7:0]  acc_q;

    int checks = 0;
    int errors = 0;

    int m_acc, m_pc, m_ir, m_mar, m_mdr;

    always #5 clock = ~clock;

    processor_datapath #(.WORD_W(8), .OP_W(3)) dut (
        .clock(clock), .n_reset(n_reset),
        .ACC_bus(ctl[15]), .PC_bus(ctl[14]), .MDR_bus(ctl[13]), .Addr_bus(ctl[12]),
        .load_ACC(ctl[11]), .load_PC(ctl[10]), .load_IR(ctl[9]),
        .load_MAR(ctl[8]), .load_MDR(ctl[7]),
        .ALU_ACC(ctl[6]), .ALU_add(ctl[5]), .ALU_sub(ctl[4]), .ALU_xor(ctl[3]),
        .INC_PC(ctl[2]), .CS(ctl[1]), .R_NW(ctl[0]),
        .op(op), .z_flag(z_flag), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(rdata), .mem_cs(mem_cs), .mem_we(mem_we),
        .bus_conflict(bus_conflict), .acc_q(acc_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".op"},    32'(op),        32'(m_ir / 32));
        check({tag, ".z"},     32'(z_flag),    32'(m_acc == 0));
        check({tag, ".addr"},  32'(mem_addr),  32'(m_mar));
        check({tag, ".wdata"}, 32'(mem_wdata), 32'(m_mdr));
        check({tag, ".acc"},   32'(acc_q),     32'(m_acc));
    endtask

    task automatic model_clear();
        m_acc = 0; m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0;
    endtask

    // One clock cycle: drive at negedge, check strobes, advance model, check registers.
    task automatic step(input string tag, input logic [15:0] c, input logic [7:0] rd);
        int b, alu, en;
        int n_acc, n_pc, n_ir, n_mar, n_mdr;
        @(negedge clock);
        ctl = c;
        rdata = rd;
        #1;
        if (c[15])      b = m_acc;
        else if (c[14]) b = m_pc;
        else if (c[13]) b = m_mdr;
        else if (c[12]) b = m_ir % 32;
        else            b = 0;
        en = int'(c[15]) + int'(c[14]) + int'(c[13]) + int'(c[12]);
        check({tag, ".conflict"}, 32'(bus_conflict), 32'(en > 1));
        check({tag, ".cs"},       32'(mem_cs),       32'(c[1]));
        check({tag, ".we"},       32'(mem_we),       32'(c[1] && !c[0]));

        if (c[5])      alu = (m_acc + b) % 256;
        else if (c[4]) alu = (m_acc - b + 256) % 256;
        else if (c[3]) alu = m_acc ^ b;
        else           alu = b;
        n_acc = c[11] ? (c[6] ? alu : b) : m_acc;
        n_pc  = c[10] ? (c[2] ? (m_pc + 1) % 32 : b % 32) : m_pc;
        n_ir  = c[9]  ? b : m_ir;
        n_mar = c[8]  ? b % 32 : m_mar;
        n_mdr = c[7]  ? b : ((c[1] && c[0]) ? int'(rd) : m_mdr);

        @(posedge clock);
        #1;
        m_acc = n_acc; m_pc = n_pc; m_ir = n_ir; m_mar = n_mar; m_mdr = n_mdr;
        check_regs(tag);
    endtask

    task automatic mid_reset(input string tag, input logic [15:0] c);
        @(negedge clock);
        ctl = c;
        rdata = 8'hA5;
        #2;
        n_reset = 1'b0;
        #1;
        model_clear();
        check_regs({tag, ".async"});
        @(posedge clock);
        #1;
        check_regs({tag, ".held"});
        @(negedge clock);
        ctl = '0;
        n_reset = 1'b1;
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        check_regs("reset");
        check("reset.z_const", 32'(z_flag), 32'd1);
        @(negedge clock);
        n_reset = 1'b1;

        // Fetch
        step("f1", PCB | LMAR | INC | LPC, 8'h00);
        step("f2", CS | RNW, 8'h65);
        step("f3", MDRB | LIR, 8'h00);
        check("fetch.op", 32'(op), 32'd3);
        check("fetch.addr", 32'(mem_addr), 32'd0);
        step("f4", PCB | LMAR, 8'h00);
        check("fetch.pc", 32'(mem_addr), 32'd1);

        // LOAD
        step("l1", ADRB | LMAR, 8'h00);
        check("load.addr", 32'(mem_addr), 32'd5);
        step("l2", CS | RNW, 8'h00);
        step("l3", MDRB | LACC, 8'h00);
        check("load.z", 32'(z_flag), 32'd1);

        // ADD with overflow, then SUB with borrow
        step("a1", CS | RNW, 8'hF0);
        step("a2", MDRB | LACC, 8'h00);
        step("a3", CS | RNW, 8'h20);
        step("a4", MDRB | AACC | ADD | LACC, 8'h00);
        check("add.acc", 32'(acc_q), 32'h10);
        check("add.z", 32'(z_flag), 32'd0);
        step("s1", MDRB | AACC | SUB | LACC, 8'h00);
        check("sub.acc", 32'(acc_q), 32'hF0);

        // STORE
        step("w1", CS | RNW, 8'h5A);
        step("w2", MDRB | LACC, 8'h00);
        step("w3", ACCB | LMDR, 8'h00);
        step("w4", CS, 8'h00);
        check("store.wdata", 32'(mem_wdata), 32'h5A);
        step("w5", 16'h0000, 8'h00);

        // PC wrap and branch
        step("p1", CS | RNW, 8'h1F);
        step("p2", MDRB | LPC, 8'h00);
        step("p3", LPC | INC, 8'h00);
        step("p4", PCB | LMAR, 8'h00);
        check("wrap.pc", 32'(mem_addr), 32'd0);
        step("p5", CS | RNW, 8'h0C);
        step("p6", MDRB | LPC, 8'h00);
        step("p7", PCB | LMAR, 8'h00);
        check("branch.pc", 32'(mem_addr), 32'd12);

        // Conflict: ACC wins the bus
        step("c1", CS | RNW, 8'h5A);
        step("c2", MDRB | LACC, 8'h00);
        step("c3", CS | RNW, 8'h0C);
        step("c4", ACCB | MDRB | LIR, 8'h00);
        check("conflict.op", 32'(op), 32'd2);

        // Reset during an active cycle
        mid_reset("rst1", ACCB | LACC | LPC | LIR | LMAR | LMDR | CS | RNW);
        check("rst1.z_const", 32'(z_flag), 32'd1);

        // Random control sequences
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0)
                mid_reset("rrst", 16'($urandom));
            else
                step("rand", 16'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
